// File: rtl/axi_burst_addr_gen_pkg.sv
// Shared types for the AXI burst address generator: burst size/type enums, latched
// burst configuration and the 4 KB boundary constant.
package axi_burst_addr_gen_pkg;

   localparam int unsigned LEN_W           = 8;
   localparam int unsigned SIZE_W          = 3;
   localparam int unsigned BURST_W         = 2;
   localparam int unsigned AXI_4K_BOUNDARY = 4096;

   typedef enum logic [SIZE_W-1:0] {
      SIZE_1B   = 3'd0,
      SIZE_2B   = 3'd1,
      SIZE_4B   = 3'd2,
      SIZE_8B   = 3'd3,
      SIZE_16B  = 3'd4,
      SIZE_32B  = 3'd5,
      SIZE_64B  = 3'd6,
      SIZE_128B = 3'd7
   } burst_size_e;

   typedef enum logic [BURST_W-1:0] {
      BURST_FIXED = 2'd0,
      BURST_INCR  = 2'd1,
      BURST_WRAP  = 2'd2
   } burst_type_e;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } gen_state_e;

   typedef struct packed {
      logic [LEN_W-1:0] len;
      burst_size_e      size;
      burst_type_e      burst;
   } burst_cfg_t;

   // Reserved type and WRAP with an illegal length both degrade to INCR.
   function automatic burst_type_e eff_burst(input logic [BURST_W-1:0] burst,
                                             input logic [LEN_W-1:0]   len);
      logic wrap_len_ok;
      wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
      case (burst)
         2'd0:    eff_burst = BURST_FIXED;
         2'd2:    eff_burst = wrap_len_ok ? BURST_WRAP : BURST_INCR;
         default: eff_burst = BURST_INCR;
      endcase
   endfunction

endpackage

// File: rtl/axi_burst_addr_gen_if.sv
// Command and beat channels of the burst address generator.
// beat_err_o exists only when AXI_ADDR_GEN_4K_CHECK_EN is defined.
interface axi_burst_addr_gen_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned ID_W   = 4
);
   logic              cmd_valid_i;
   logic              cmd_ready_o;
   logic [ADDR_W-1:0] cmd_addr_i;
   logic [7:0]        cmd_len_i;
   logic [2:0]        cmd_size_i;
   logic [1:0]        cmd_burst_i;
   logic [ID_W-1:0]   cmd_id_i;
   logic              beat_valid_o;
   logic              beat_ready_i;
   logic [ADDR_W-1:0] beat_addr_o;
   logic [7:0]        beat_idx_o;
   logic              beat_last_o;
   logic [ID_W-1:0]   beat_id_o;
`ifdef AXI_ADDR_GEN_4K_CHECK_EN
   logic              beat_err_o;
`endif

   modport slave (
      input  cmd_valid_i, cmd_addr_i, cmd_len_i, cmd_size_i, cmd_burst_i, cmd_id_i,
             beat_ready_i,
      output cmd_ready_o, beat_valid_o, beat_addr_o, beat_idx_o, beat_last_o, beat_id_o
`ifdef AXI_ADDR_GEN_4K_CHECK_EN
      , beat_err_o
`endif
   );

   modport master (
      output cmd_valid_i, cmd_addr_i, cmd_len_i, cmd_size_i, cmd_burst_i, cmd_id_i,
             beat_ready_i,
      input  cmd_ready_o, beat_valid_o, beat_addr_o, beat_idx_o, beat_last_o, beat_id_o
`ifdef AXI_ADDR_GEN_4K_CHECK_EN
      , beat_err_o
`endif
   );

endinterface

// File: rtl/axi_burst_next_addr.sv
// Combinational next-beat address for FIXED / INCR / WRAP bursts given the current beat
// address; burst is expected to be the effective type (illegal WRAP already mapped to INCR).
module axi_burst_next_addr
   import axi_burst_addr_gen_pkg::*;
#(
   parameter int unsigned ADDR_W = 32
) (
   input  logic [ADDR_W-1:0] cur_addr,
   input  logic [7:0]        len,
   input  burst_size_e       size,
   input  burst_type_e       burst,
   output logic [ADDR_W-1:0] next_addr
);

   logic [ADDR_W-1:0] bytes;
   logic [ADDR_W-1:0] total;
   logic [ADDR_W-1:0] incr_addr;

   // Wrap is formed by OR-ing the in-window offset onto the window base so it never
   // depends on base+total, which can overflow at the top of the address space.
   always_comb begin
      bytes     = ADDR_W'(1) << size;
      total     = (ADDR_W'(len) + ADDR_W'(1)) << size;
      incr_addr = (cur_addr & ~(bytes - ADDR_W'(1))) + bytes;
      case (burst)
         BURST_FIXED: next_addr = cur_addr;
         BURST_WRAP:  next_addr = (cur_addr & ~(total - ADDR_W'(1)))
                                | (incr_addr & (total - ADDR_W'(1)));
         default:     next_addr = incr_addr;
      endcase
   end

endmodule

// File: rtl/axi_burst_addr_gen.sv
// Expands one AXI4 address command into a per-beat address stream, one beat per handshake.
// Optional 4 KB crossing flag for INCR bursts: define AXI_ADDR_GEN_4K_CHECK_EN.
module axi_burst_addr_gen
   import axi_burst_addr_gen_pkg::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned ID_W   = 4
) (
   input logic               clk_i,
   input logic               rst_i,
   axi_burst_addr_gen_if.slave bus
);

   gen_state_e        state_q, state_d;
   burst_cfg_t        cfg_q, cfg_d;
   logic              beat_valid_q, beat_valid_d;
   logic [ADDR_W-1:0] beat_addr_q, beat_addr_d;
   logic [7:0]        beat_idx_q, beat_idx_d;
   logic              beat_last_q, beat_last_d;
   logic [ID_W-1:0]   beat_id_q, beat_id_d;
   logic [ADDR_W-1:0] next_addr;
   burst_type_e       cmd_burst_eff;

   assign cmd_burst_eff = eff_burst(bus.cmd_burst_i, bus.cmd_len_i);

   axi_burst_next_addr #(.ADDR_W(ADDR_W)) u_next_addr (
      .cur_addr  (beat_addr_q),
      .len       (cfg_q.len),
      .size      (cfg_q.size),
      .burst     (cfg_q.burst),
      .next_addr (next_addr)
   );

`ifdef AXI_ADDR_GEN_4K_CHECK_EN
   logic        err_q, err_d;
   logic [11:0] cmd_off;
   logic [16:0] cmd_span;
   logic        cmd_err;

   // Crossing when the size-aligned 4 KB offset plus total burst bytes exceeds one page.
   always_comb begin
      cmd_off  = bus.cmd_addr_i[11:0] & ~((12'(1) << bus.cmd_size_i) - 12'd1);
      cmd_span = 17'(cmd_off) + ((17'(bus.cmd_len_i) + 17'd1) << bus.cmd_size_i);
      cmd_err  = (cmd_burst_eff == BURST_INCR) && (cmd_span > 17'(AXI_4K_BOUNDARY));
   end
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d      = state_q;
      cfg_d        = cfg_q;
      beat_valid_d = beat_valid_q;
      beat_addr_d  = beat_addr_q;
      beat_idx_d   = beat_idx_q;
      beat_last_d  = beat_last_q;
      beat_id_d    = beat_id_q;
`ifdef AXI_ADDR_GEN_4K_CHECK_EN
      err_d        = err_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (bus.cmd_valid_i) begin
               state_d      = ST_BURST;
               cfg_d        = '{len: bus.cmd_len_i, size: burst_size_e'(bus.cmd_size_i),
                                burst: cmd_burst_eff};
               beat_valid_d = 1'b1;
               beat_addr_d  = bus.cmd_addr_i;
               beat_idx_d   = 8'd0;
               beat_last_d  = (bus.cmd_len_i == 8'd0);
               beat_id_d    = bus.cmd_id_i;
`ifdef AXI_ADDR_GEN_4K_CHECK_EN
               err_d        = cmd_err;
`endif
            end
         end
         ST_BURST: begin
            if (bus.beat_ready_i) begin
               if (beat_last_q) begin
                  state_d      = ST_IDLE;
                  beat_valid_d = 1'b0;
               end else begin
                  beat_idx_d  = beat_idx_q + 8'd1;
                  beat_addr_d = next_addr;
                  beat_last_d = ((beat_idx_q + 8'd1) == cfg_q.len);
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cfg_q        <= '0;
         beat_valid_q <= 1'b0;
         beat_addr_q  <= '0;
         beat_idx_q   <= '0;
         beat_last_q  <= 1'b0;
         beat_id_q    <= '0;
`ifdef AXI_ADDR_GEN_4K_CHECK_EN
         err_q        <= 1'b0;
`endif
      end else begin
         cfg_q        <= cfg_d;
         beat_valid_q <= beat_valid_d;
         beat_addr_q  <= beat_addr_d;
         beat_idx_q   <= beat_idx_d;
         beat_last_q  <= beat_last_d;
         beat_id_q    <= beat_id_d;
`ifdef AXI_ADDR_GEN_4K_CHECK_EN
         err_q        <= err_d;
`endif
      end
   end

   assign bus.cmd_ready_o  = (state_q == ST_IDLE);
   assign bus.beat_valid_o = beat_valid_q;
   assign bus.beat_addr_o  = beat_addr_q;
   assign bus.beat_idx_o   = beat_idx_q;
   assign bus.beat_last_o  = beat_last_q;
   assign bus.beat_id_o    = beat_id_q;
`ifdef AXI_ADDR_GEN_4K_CHECK_EN
   assign bus.beat_err_o   = err_q;
`endif

endmodule

// File: tb/tb_axi_burst_addr_gen.sv
// Directed bench for axi_burst_addr_gen: expected beats are queued when a command is
// issued and compared as the DUT presents them. Honours AXI_ADDR_GEN_4K_CHECK_EN.
module tb_axi_burst_addr_gen;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned ID_W   = 4;

   logic clk_i = 1'b0;
   logic rst_i;

   always #5 clk_i = ~clk_i;

   axi_burst_addr_gen_if #(.ADDR_W(ADDR_W), .ID_W(ID_W)) bus ();

   axi_burst_addr_gen #(.ADDR_W(ADDR_W), .ID_W(ID_W)) dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (bus.slave)
   );

   typedef struct {
      logic [31:0] addr;
      logic [7:0]  idx;
      logic        last;
      logic [3:0]  id;
      logic        err;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Beat n address straight from the closed-form definitions, in 64-bit arithmetic.
   function automatic logic [31:0] model_addr(input logic [31:0] addr, input int len,
                                              input int size, input int burst, input int n);
      longint unsigned b, a0, t, w, x;
      b  = 64'd1 << size;
      a0 = {32'd0, addr} & ~(b - 64'd1);
      if (burst == 0 || n == 0) return addr;
      x = a0 + longint'(n) * b;
      if (burst == 2 && (len == 1 || len == 3 || len == 7 || len == 15)) begin
         t = longint'(len + 1) * b;
         w = {32'd0, addr} & ~(t - 64'd1);
         if (x >= w + t) x = x - t;
      end
      return x[31:0];
   endfunction

   function automatic logic model_err(input logic [31:0] addr, input int len,
                                      input int size, input int burst);
      longint unsigned b, a0, t;
      logic is_incr;
      is_incr = (burst == 1) || (burst == 3) ||
                (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15));
      b  = 64'd1 << size;
      a0 = {32'd0, addr} & ~(b - 64'd1);
      t  = longint'(len + 1) * b;
      return is_incr && (((a0 & 64'hFFF) + t) > 64'd4096);
   endfunction

   task automatic send_cmd(input logic [31:0] addr, input int len, input int size,
                           input int burst, input logic [3:0] id);
      int   k;
      exp_t e;
      for (int n = 0; n <= len; n++) begin
         e.addr = model_addr(addr, len, size, burst, n);
         e.idx  = 8'(n);
         e.last = (n == len);
         e.id   = id;
         e.err  = model_err(addr, len, size, burst);
         sb.push_back(e);
      end
      bus.cmd_valid_i = 1'b1;
      bus.cmd_addr_i  = addr;
      bus.cmd_len_i   = 8'(len);
      bus.cmd_size_i  = 3'(size);
      bus.cmd_burst_i = 2'(burst);
      bus.cmd_id_i    = id;
      k = 0;
      while (!bus.cmd_ready_o && k < 20) begin
         @(negedge clk_i);
         k++;
      end
      chk("cmd_handshake_timeout", 64'(k < 20), 64'd1);
      @(negedge clk_i);
      bus.cmd_valid_i = 1'b0;
      chk("cmd_ready_in_burst", 64'(bus.cmd_ready_o), 64'd0);
   endtask

   // Consume beats against the scoreboard; optionally stall one beat, or stop after max_hs.
   task automatic run_beats(input int stall_idx, input int stall_cycles, input int max_hs);
      int   hs, stalled, budget;
      exp_t e;
      hs = 0;
      stalled = 0;
      budget = 0;
      while (sb.size() > 0 && hs != max_hs && budget < 500) begin
         budget++;
         if (bus.beat_valid_o) begin
            e = sb[0];
            chk("beat_addr", 64'(bus.beat_addr_o), 64'(e.addr));
            chk("beat_idx",  64'(bus.beat_idx_o),  64'(e.idx));
            chk("beat_last", 64'(bus.beat_last_o), 64'(e.last));
            chk("beat_id",   64'(bus.beat_id_o),   64'(e.id));
`ifdef AXI_ADDR_GEN_4K_CHECK_EN
            chk("beat_err",  64'(bus.beat_err_o),  64'(e.err));
`endif
            if (int'(e.idx) == stall_idx && stalled < stall_cycles) begin
               bus.beat_ready_i = 1'b0;
               stalled++;
            end else begin
               bus.beat_ready_i = 1'b1;
               void'(sb.pop_front());
               hs++;
            end
         end else begin
            bus.beat_ready_i = 1'b1;
         end
         @(negedge clk_i);
      end
      chk("beat_timeout", 64'(budget < 500), 64'd1);
      bus.beat_ready_i = 1'b0;
   endtask

   task automatic chk_idle();
      chk("idle_beat_valid", 64'(bus.beat_valid_o), 64'd0);
      chk("idle_cmd_ready",  64'(bus.cmd_ready_o),  64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_i            = 1'b1;
      bus.cmd_valid_i  = 1'b0;
      bus.cmd_addr_i   = '0;
      bus.cmd_len_i    = '0;
      bus.cmd_size_i   = '0;
      bus.cmd_burst_i  = '0;
      bus.cmd_id_i     = '0;
      bus.beat_ready_i = 1'b0;
      repeat (2) @(negedge clk_i);

      chk("rst_beat_valid", 64'(bus.beat_valid_o), 64'd0);
      chk("rst_beat_addr",  64'(bus.beat_addr_o),  64'd0);
      chk("rst_beat_idx",   64'(bus.beat_idx_o),   64'd0);
      chk("rst_beat_last",  64'(bus.beat_last_o),  64'd0);
      chk("rst_beat_id",    64'(bus.beat_id_o),    64'd0);
      chk("rst_cmd_ready",  64'(bus.cmd_ready_o),  64'd1);
`ifdef AXI_ADDR_GEN_4K_CHECK_EN
      chk("rst_beat_err",   64'(bus.beat_err_o),   64'd0);
`endif
      rst_i = 1'b0;
      @(negedge clk_i);

      // INCR aligned and unaligned
      send_cmd(32'h0000_1004, 3, 2, 1, 4'h1);
      run_beats(-1, 0, -1);
      chk_idle();
      send_cmd(32'h0000_1003, 2, 2, 1, 4'h2);
      run_beats(-1, 0, -1);
      chk_idle();

      // WRAP legal length, then WRAP len=2 degrading to INCR
      send_cmd(32'h0000_0038, 3, 3, 2, 4'h3);
      run_beats(-1, 0, -1);
      send_cmd(32'h0000_0038, 2, 3, 2, 4'h4);
      run_beats(-1, 0, -1);
      chk_idle();

      // FIXED with a 3-cycle stall on beat 1
      send_cmd(32'h0000_0200, 2, 2, 0, 4'h5);
      run_beats(1, 3, -1);
      chk_idle();

      // Reserved type as INCR, single-beat burst, address space rollover
      send_cmd(32'h0000_0100, 1, 2, 3, 4'h6);
      run_beats(-1, 0, -1);
      send_cmd(32'h0000_0044, 0, 2, 1, 4'h7);
      run_beats(-1, 0, -1);
      send_cmd(32'hFFFF_FFF8, 1, 3, 1, 4'h8);
      run_beats(-1, 0, -1);
      chk_idle();

      // Reset after beat 1 of an 8-beat INCR
      send_cmd(32'h0000_2000, 7, 2, 1, 4'h9);
      run_beats(-1, 0, 2);
      rst_i = 1'b1;
      @(negedge clk_i);
      chk("midrst_beat_valid", 64'(bus.beat_valid_o), 64'd0);
      chk("midrst_cmd_ready",  64'(bus.cmd_ready_o),  64'd1);
      rst_i = 1'b0;
      sb.delete();
      repeat (3) begin
         @(negedge clk_i);
         chk("no_residual_beat", 64'(bus.beat_valid_o), 64'd0);
      end
      send_cmd(32'h0000_3000, 1, 2, 1, 4'hA);
      run_beats(-1, 0, -1);
      chk_idle();

      // 4 KB crossing and exactly-at-boundary cases
      send_cmd(32'h0000_0FF8, 1, 3, 1, 4'hB);
      run_beats(-1, 0, -1);
      send_cmd(32'h0000_0FF0, 1, 3, 1, 4'hC);
      run_beats(-1, 0, -1);
      chk_idle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
